cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Run/halt sequencer for the pipelined CPU and arbiter for its 512-word data memory.
//  Holds the CPU idle until start, counts run cycles, and halts it on the MEM/WB finish flag or on timeout.
//  After halting, it takes over the data memory read port and streams every word out on a valid/ready dump port.
//  Replaces the bench-side cycle counter, finish watch and memory dump with synthesizable logic.
// PARAMETERS
//  DEPTH    512  data memory words dumped (addresses 0..DEPTH-1)
//  ADDR_W   9    memory address width, clog2(DEPTH)
//  DATA_W   32   memory word width
//  CYC_W    32   cycle counter width
//  TIMEOUT  300  run cycles before forced halt (3000 ns at 10 ns clock)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       pulse; begins a run (honoured in IDLE only)
//  finish_in   in   1       MEM/WB finish flag from the pipeline (level)
//  cpu_en      out  1       1 = pipeline may advance; 0 = all stages stalled
//  mem_sel     out  1       data memory port owner: 0 = CPU MEM stage, 1 = controller
//  mem_raddr   out  ADDR_W  controller read address (meaningful when mem_sel=1)
//  mem_rdata   in   DATA_W  memory read data, valid 1 cycle after mem_raddr
//  dump_valid  out  1       dump word available
//  dump_ready  in   1       consumer accepts the word when valid&ready
//  dump_addr   out  ADDR_W  address of the current dump word
//  dump_data   out  DATA_W  contents of the current dump word
//  dump_last   out  1       current word is address DEPTH-1
//  cycle_count out  CYC_W   run cycles used (stable after RUN exits)
//  done        out  1       dump complete (sticky)
//  timed_out   out  1       run ended by TIMEOUT rather than finish_in (sticky)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. All outputs are 0, including the counter, index and dump registers.
//  States: IDLE, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
//  IDLE: cpu_en=0, mem_sel=0. When start=1, go to RUN and clear cycle_count, timed_out and the index.
//  RUN: cpu_en=1, mem_sel=0, cycle_count += 1 every RUN cycle.
//   - The count includes the cycle in which finish_in is seen.
//   - The count saturates at all-ones.
//   - If finish_in=1, go to DUMP_RD.
//   - Else if cycle_count+1 == TIMEOUT, set timed_out=1 and go to DUMP_RD.
//   - If finish_in and the timeout fire in the same cycle, finish wins and timed_out stays 0.
//  Once RUN exits, cpu_en=0 and mem_sel=1 until reset, so no CPU memory access can occur during the dump.
//  DUMP_RD: mem_raddr=idx; go to DUMP_CAP.
//  DUMP_CAP: dump_data <= mem_rdata, dump_addr <= idx; go to DUMP_OUT.
//  DUMP_OUT: dump_valid=1, dump_last=(idx==DEPTH-1).
//   - dump_data, dump_addr and dump_last hold stable while dump_ready=0 (no timeout).
//   - On valid&ready with idx<DEPTH-1: idx += 1 and go to DUMP_RD.
//   - On valid&ready with last: go to DONE.
//   - Throughput is 1 word per 3 cycles minimum. Exactly DEPTH words, in ascending address order, no repeats.
//  DONE: done=1, dump_valid=0, cpu_en=0. Terminal until rst_n; start is ignored.
//  finish_in is ignored outside RUN. start is ignored outside IDLE.
//  Reset mid-run or mid-dump: immediate return to IDLE with all outputs 0. No partial word is presented.
//  idx is ADDR_W bits and never wraps past DEPTH-1.
// TESTING
//  1. Reset with start=0 for 20 cycles -> cpu_en=0, mem_sel=0, dump_valid=0, done=0, cycle_count=0.
//  2. start pulse, finish_in=1 on the 57th RUN cycle -> cycle_count=57, timed_out=0, cpu_en falls on the next edge.
//  3. Memory preloaded with word i = i*3, dump_ready=1 -> 512 words in order 0..511, data matches,
//     dump_last only on addr 511, done rises 1 cycle after the last handshake.
//  4. finish_in never asserted -> cycle_count=300, timed_out=1, full dump still occurs, done=1.
//  5. Random dump_ready backpressure (about 30% high) -> data/addr stable while stalled, no drop or duplicate,
//     finish_in and the timeout together on cycle 300 -> timed_out=0.
//  6. rst_n pulsed low during the dump at addr 100 -> outputs 0 at once.
//     A new start gives a clean run and a dump beginning at addr 0.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// Dump-port bundle: one word plus address and last flag, moved by a valid/ready handshake.
// The controller drives the word (master); the consumer returns ready (slave).
interface cpu_run_controller_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              last;

   modport master (output valid, addr, data, last, input ready);
   modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/cpu_run_controller.sv
// Run/halt sequencer for the pipelined CPU: counts run cycles, halts on finish or timeout,
// then owns the data memory read port and streams every word out on the dump interface.
module cpu_run_controller #(
   parameter int DEPTH   = 512,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int CYC_W   = 32,
   parameter int TIMEOUT = 300
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 finish_in,
   output logic                 cpu_en,
   output logic                 mem_sel,
   output logic [ADDR_W-1:0]    mem_raddr,
   input  logic [DATA_W-1:0]    mem_rdata,
   cpu_run_controller_if.master dump,
   output logic [CYC_W-1:0]     cycle_count,
   output logic                 done,
   output logic                 timed_out
);
   typedef enum logic [2:0] {IDLE, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);
   localparam logic [CYC_W-1:0]  TIMEOUT_CNT = CYC_W'(TIMEOUT);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] dump_addr_q;
   logic [DATA_W-1:0] dump_data_q;
   logic              is_last;
   logic              hit_timeout;

   assign is_last     = (idx == LAST_IDX);
   assign hit_timeout = (cycle_count + CYC_W'(1) == TIMEOUT_CNT);
   assign mem_raddr   = idx;
   assign dump.addr   = dump_addr_q;
   assign dump.data   = dump_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      cpu_en     = 1'b0;
      mem_sel    = 1'b0;
      dump.valid = 1'b0;
      dump.last  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            cpu_en = 1'b1;
            if (finish_in || hit_timeout) state_nxt = DUMP_RD;
         end
         DUMP_RD: begin
            mem_sel   = 1'b1;
            state_nxt = DUMP_CAP;
         end
         DUMP_CAP: begin
            mem_sel   = 1'b1;
            state_nxt = DUMP_OUT;
         end
         DUMP_OUT: begin
            mem_sel    = 1'b1;
            dump.valid = 1'b1;
            dump.last  = is_last;
            if (dump.ready) state_nxt = is_last ? DONE : DUMP_RD;
         end
         DONE: begin
            mem_sel = 1'b1;
            done    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: datapath registers use non-blocking assignments and clear on the async reset so no
   // stale word or count is visible after rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         cycle_count <= '0;
         timed_out   <= 1'b0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx         <= '0;
               cycle_count <= '0;
               timed_out   <= 1'b0;
            end
            RUN: begin
               if (cycle_count != '1) cycle_count <= cycle_count + CYC_W'(1);
               // finish_in wins a tie with the timeout
               if (!finish_in && hit_timeout) timed_out <= 1'b1;
            end
            DUMP_CAP: begin
               dump_data_q <= mem_rdata;
               dump_addr_q <= idx;
            end
            DUMP_OUT: if (dump.ready && !is_last) idx <= idx + ADDR_W'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: run/halt timing, timeout, full dumps with and
// without backpressure, and reset in the middle of a dump.
module tb_cpu_run_controller;
   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        finish_in;
   logic        cpu_en;
   logic        mem_sel;
   logic [8:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic [31:0] cycle_count;
   logic        done;
   logic        timed_out;
   logic [31:0] mem [DEPTH];

   int n_checks = 0;
   int n_pass   = 0;

   cpu_run_controller_if #(.ADDR_W(9), .DATA_W(32)) dump_if ();

   cpu_run_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .finish_in   (finish_in),
      .cpu_en      (cpu_en),
      .mem_sel     (mem_sel),
      .mem_raddr   (mem_raddr),
      .mem_rdata   (mem_rdata),
      .dump        (dump_if),
      .cycle_count (cycle_count),
      .done        (done),
      .timed_out   (timed_out)
   );

   always #5 clk = ~clk;

   // Synchronous-read data memory, one cycle of latency
   always @(posedge clk) mem_rdata <= mem[mem_raddr];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; finish_in = 1'b0; dump_if.ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Leaves the bench at the negedge inside RUN cycle 1
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consumes the dump from DUMP_RD onward; returns early if abort_addr is presented.
   task automatic collect_dump(input int ready_pct, input int abort_addr,
                               output int words, output int e_order, output int e_data,
                               output int e_last, output int e_stable, output int e_own,
                               output bit done_ok, output bit aborted);
      bit          stall = 0;
      bit          rdy;
      logic [8:0]  h_addr = '0;
      logic [31:0] h_data = '0;
      logic        h_last = 1'b0;
      words = 0; e_order = 0; e_data = 0; e_last = 0; e_stable = 0; e_own = 0;
      done_ok = 0; aborted = 0;
      for (int cyc = 0; cyc < 12000; cyc++) begin
         if (cpu_en !== 1'b0 || mem_sel !== 1'b1) e_own++;
         if (dump_if.valid === 1'b1) begin
            if (abort_addr >= 0 && int'(dump_if.addr) == abort_addr) begin
               aborted = 1;
               return;
            end
            if (stall && (dump_if.addr !== h_addr || dump_if.data !== h_data ||
                          dump_if.last !== h_last)) e_stable++;
         end
         rdy = ($urandom_range(99) < ready_pct);
         dump_if.ready = rdy;
         if (dump_if.valid === 1'b1) begin
            if (rdy) begin
               if (int'(dump_if.addr) != words) e_order++;
               if (dump_if.data !== 32'(words * 3)) e_data++;
               if (dump_if.last !== (words == DEPTH - 1)) e_last++;
               words++;
               stall = 0;
               if (words == DEPTH) begin
                  done_ok = (done === 1'b0);
                  @(negedge clk);
                  dump_if.ready = 1'b0;
                  done_ok = done_ok && (done === 1'b1) && (dump_if.valid === 1'b0);
                  return;
               end
            end else begin
               stall  = 1;
               h_addr = dump_if.addr;
               h_data = dump_if.data;
               h_last = dump_if.last;
            end
         end
         @(negedge clk);
      end
      dump_if.ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; finish_in = 1'b0; dump_if.ready = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++; if (cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b want 0", cpu_en); else n_pass++;
      n_checks++; if (mem_sel !== 1'b0) $display("FAIL reset_mem_sel: got %b want 0", mem_sel); else n_pass++;
      n_checks++; if (dump_if.valid !== 1'b0) $display("FAIL reset_dump_valid: got %b want 0", dump_if.valid); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); else n_pass++;
      n_checks++; if (timed_out !== 1'b0) $display("FAIL reset_timed_out: got %b want 0", timed_out); else n_pass++;
      rst_n = 1'b1;
      finish_in = 1'b1;
      repeat (4) @(negedge clk);
      finish_in = 1'b0;
      n_checks++; if (cpu_en !== 1'b0 || mem_sel !== 1'b0) $display("FAIL idle_ignores_finish: cpu_en=%b mem_sel=%b want 0/0", cpu_en, mem_sel); else n_pass++;
   endtask

   task automatic test_finish_halt();
      pulse_start();
      n_checks++; if (cpu_en !== 1'b1) $display("FAIL run_cpu_en: got %b want 1", cpu_en); else n_pass++;
      n_checks++; if (cycle_count !== 32'd0) $display("FAIL run_first_count: got %0d want 0", cycle_count); else n_pass++;
      repeat (56) @(negedge clk);
      finish_in = 1'b1;
      n_checks++; if (cpu_en !== 1'b1) $display("FAIL finish_cycle_cpu_en: got %b want 1", cpu_en); else n_pass++;
      @(negedge clk);
      finish_in = 1'b0;
      n_checks++; if (cpu_en !== 1'b0) $display("FAIL finish_cpu_en_fall: got %b want 0", cpu_en); else n_pass++;
      n_checks++; if (mem_sel !== 1'b1) $display("FAIL finish_mem_sel: got %b want 1", mem_sel); else n_pass++;
      n_checks++; if (cycle_count !== 32'd57) $display("FAIL finish_cycle_count: got %0d want 57", cycle_count); else n_pass++;
      n_checks++; if (timed_out !== 1'b0) $display("FAIL finish_timed_out: got %b want 0", timed_out); else n_pass++;
   endtask

   task automatic check_full_dump(input string tag, input int ready_pct);
      int words, e_order, e_data, e_last, e_stable, e_own;
      bit done_ok, aborted;
      collect_dump(ready_pct, -1, words, e_order, e_data, e_last, e_stable, e_own, done_ok, aborted);
      n_checks++; if (words != DEPTH) $display("FAIL %s_words: got %0d want %0d", tag, words, DEPTH); else n_pass++;
      n_checks++; if (e_order != 0) $display("FAIL %s_order: %0d out-of-order words, want 0", tag, e_order); else n_pass++;
      n_checks++; if (e_data != 0) $display("FAIL %s_data: %0d bad words, want 0", tag, e_data); else n_pass++;
      n_checks++; if (e_last != 0) $display("FAIL %s_last: %0d bad last flags, want 0", tag, e_last); else n_pass++;
      n_checks++; if (e_stable != 0) $display("FAIL %s_stable: %0d changes while stalled, want 0", tag, e_stable); else n_pass++;
      n_checks++; if (e_own != 0) $display("FAIL %s_ownership: %0d cycles with cpu_en/mem_sel wrong, want 0", tag, e_own); else n_pass++;
      n_checks++; if (!done_ok) $display("FAIL %s_done: got done=%b want rise 1 cycle after last handshake", tag, done); else n_pass++;
   endtask

   task automatic test_full_dump();
      check_full_dump("dump", 100);
      pulse_start();
      repeat (3) @(negedge clk);
      n_checks++; if (done !== 1'b1 || cpu_en !== 1'b0 || mem_sel !== 1'b1) $display("FAIL done_ignores_start: done=%b cpu_en=%b mem_sel=%b want 1/0/1", done, cpu_en, mem_sel); else n_pass++;
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_start();
      repeat (299) @(negedge clk);
      n_checks++; if (cpu_en !== 1'b1 || cycle_count !== 32'd299) $display("FAIL timeout_pre: cpu_en=%b count=%0d want 1/299", cpu_en, cycle_count); else n_pass++;
      @(negedge clk);
      n_checks++; if (cpu_en !== 1'b0) $display("FAIL timeout_cpu_en: got %b want 0", cpu_en); else n_pass++;
      n_checks++; if (cycle_count !== 32'd300) $display("FAIL timeout_count: got %0d want 300", cycle_count); else n_pass++;
      n_checks++; if (timed_out !== 1'b1) $display("FAIL timeout_flag: got %b want 1", timed_out); else n_pass++;
      check_full_dump("timeout_dump", 100);
   endtask

   task automatic test_backpressure_tie();
      do_reset();
      pulse_start();
      repeat (299) @(negedge clk);
      finish_in = 1'b1;
      @(negedge clk);
      finish_in = 1'b0;
      n_checks++; if (cycle_count !== 32'd300) $display("FAIL tie_count: got %0d want 300", cycle_count); else n_pass++;
      n_checks++; if (timed_out !== 1'b0) $display("FAIL tie_timed_out: got %b want 0", timed_out); else n_pass++;
      check_full_dump("bp_dump", 30);
   endtask

   task automatic test_reset_mid_dump();
      int words, e_order, e_data, e_last, e_stable, e_own;
      bit done_ok, aborted;
      do_reset();
      pulse_start();
      repeat (9) @(negedge clk);
      finish_in = 1'b1;
      @(negedge clk);
      finish_in = 1'b0;
      collect_dump(100, 100, words, e_order, e_data, e_last, e_stable, e_own, done_ok, aborted);
      n_checks++; if (!aborted) $display("FAIL abort_reached: addr 100 never presented, got %0d words", words); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (cpu_en !== 1'b0 || mem_sel !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0) $display("FAIL midreset_ctrl: cpu_en=%b mem_sel=%b done=%b timed_out=%b want 0", cpu_en, mem_sel, done, timed_out); else n_pass++;
      n_checks++; if (dump_if.valid !== 1'b0 || dump_if.last !== 1'b0) $display("FAIL midreset_valid: valid=%b last=%b want 0", dump_if.valid, dump_if.last); else n_pass++;
      n_checks++; if (dump_if.addr !== 9'd0 || dump_if.data !== 32'd0 || mem_raddr !== 9'd0) $display("FAIL midreset_regs: addr=%0d data=%0h raddr=%0d want 0", dump_if.addr, dump_if.data, mem_raddr); else n_pass++;
      n_checks++; if (cycle_count !== 32'd0) $display("FAIL midreset_count: got %0d want 0", cycle_count); else n_pass++;
      dump_if.ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      repeat (4) @(negedge clk);
      finish_in = 1'b1;
      @(negedge clk);
      finish_in = 1'b0;
      n_checks++; if (cycle_count !== 32'd5 || timed_out !== 1'b0) $display("FAIL rerun_count: count=%0d timed_out=%b want 5/0", cycle_count, timed_out); else n_pass++;
      check_full_dump("rerun_dump", 100);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 3);
      test_reset();
      test_finish_halt();
      test_full_dump();
      test_timeout();
      test_backpressure_tie();
      test_reset_mid_dump();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
